// File: rtl/wallace_mac_acc.sv
// wallace_mac_acc: multiply-accumulate back end for the 8x8 Wallace-tree product stream
//
// Accumulates up to LEN unsigned 16-bit products into an ACC_W-bit register.
// A vector ends when LEN products have been accepted or when i_in_last is set.
// The result is then offered downstream with a valid/ready handshake.
//
// Build option:
//   WALLACE_MAC_SAT_EN  When defined, the accumulator saturates to all ones on
//                       carry-out. When undefined, it wraps modulo 2^ACC_W.
//
// Parameters:
//   ACC_W  accumulator/result width (17..32)
//   LEN    products per full vector (1..255)
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_clear      synchronous abort of the vector in progress
//   i_prod       unsigned product from the multiplier
//   i_in_valid   i_prod / i_in_last valid this cycle
//   i_in_last    final product of a short vector
//   o_in_ready   block accepts a product this cycle (registered, state only)
//   o_acc_out    registered result of the last completed vector
//   o_ovf        carry-out occurred during the reported vector
//   o_cnt_out    number of products in the reported vector
//   o_out_valid  result valid
//   i_out_ready  downstream accepts the result
module wallace_mac_acc #(
    parameter int ACC_W = 24,
    parameter int LEN   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [15:0]      i_prod,
    input  logic             i_in_valid,
    input  logic             i_in_last,
    output logic             o_in_ready,
    output logic [ACC_W-1:0] o_acc_out,
    output logic             o_ovf,
    output logic [7:0]       o_cnt_out,
    output logic             o_out_valid,
    input  logic             i_out_ready
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf_acc;
    logic [ACC_W-1:0] r_acc_out;
    logic [7:0]       r_cnt_out;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_accept;
    logic             w_last;

    // One extra bit on the adder exposes the carry-out of the ACC_W-bit add.
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, i_prod};
    assign w_carry   = w_sum[ACC_W];
`ifdef WALLACE_MAC_SAT_EN
    // Once at all ones, any non-zero product carries again, so saturation holds.
    assign w_acc_nxt = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_ovf_nxt = r_ovf_acc | w_carry;
    assign w_accept  = i_in_valid & r_in_ready & (r_state == ACCUM);
    assign w_last    = i_in_last | (r_cnt == 8'(LEN-1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_acc_out   <= '0;
            r_cnt_out   <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (i_clear) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (r_state == ACCUM) begin
            r_in_ready <= 1'b1;
            if (w_accept) begin
                r_acc     <= w_acc_nxt;
                r_cnt     <= w_cnt_nxt;
                r_ovf_acc <= w_ovf_nxt;
                if (w_last) begin
                    r_state     <= HOLD;
                    r_acc_out   <= w_acc_nxt;
                    r_cnt_out   <= w_cnt_nxt;
                    r_ovf       <= w_ovf_nxt;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b1;
                end
            end
        end else if (i_out_ready) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_acc_out   = r_acc_out;
    assign o_cnt_out   = r_cnt_out;
    assign o_ovf       = r_ovf;
    assign o_out_valid = r_out_valid;
endmodule
